// File: rtl/rom_arbiter_pkg.sv
// ============================================================================
// Module  : rom_arbiter_pkg
// Purpose : Shared constants, types and helpers for the ROM arbiter slice.
//           Holds the default ROM depth, FSM state codes, owner codes and
//           the address-legality helper used when a grant is issued.
// Config  : ROM_SIZE_WORDS is the default ROM depth in 32-bit words.
//           ROM_ARB_RR_EN selects round-robin arbitration in rom_arbiter
//           (not used in this file).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rom_arbiter_pkg;

    localparam int unsigned ROM_SIZE_WORDS = 1024;

    // Arbiter FSM state codes
    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_BUSY = 1'b1;

    // Owner of the access currently in flight
    localparam logic [1:0] ARB_OWN_NONE = 2'd0;
    localparam logic [1:0] ARB_OWN_IF   = 2'd1;
    localparam logic [1:0] ARB_OWN_LS   = 2'd2;

    // Everything that has to be remembered about the access in flight.
    // The request payload itself is not kept: requesters hold it until ready.
    typedef struct packed {
        logic [1:0] owner;
        logic       err;    // access was rejected, ROM was never touched
    } arb_inflight_t;

    // A byte address is serviceable when it is word aligned and inside the ROM.
    // The compare is done at 34 bits so 4*words cannot wrap.
    function automatic logic addr_legal(input logic [31:0] addr,
                                        input int unsigned words);
        logic [33:0] limit;
        limit = 34'(words) << 2;
        return (addr[1:0] == 2'b00) && ({2'b00, addr} < limit);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rom_arbiter_if.sv
// ============================================================================
// Module  : rom_arbiter_if
// Purpose : One requester channel of the ROM arbiter: a valid/ready request
//           carrying a byte address, and a single-cycle response strobe with
//           read data and an error flag (no backpressure on the response).
// Ports   : req_valid  requester -> arbiter  request pending
//           req_addr   requester -> arbiter  byte address (stable until ready)
//           req_ready  arbiter -> requester  request granted this cycle
//           resp_valid arbiter -> requester  response strobe (1 cycle)
//           resp_data  arbiter -> requester  read data (0 on error)
//           resp_err   arbiter -> requester  out of range / misaligned
// Modports: master = requester side, slave = arbiter side.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface rom_arbiter_if;

  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  resp_valid,
    input  resp_data,
    input  resp_err
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output resp_valid,
    output resp_data,
    output resp_err
  );

endinterface

`default_nettype wire

// File: rtl/rom_arb_pick.sv
// ============================================================================
// Module  : rom_arb_pick
// Purpose : Two-way combinational picker. Turns the two request valids plus
//           a preference bit into a one-hot (or all-zero) grant vector.
//           On contention the preferred side wins; otherwise whoever is
//           valid wins. Both grants are never high together.
// Ports   : valid_if   in   IF request pending
//           valid_ls   in   LS request pending
//           favour_ls  in   1 = LS wins a tie, 0 = IF wins a tie
//           grant_if   out  IF selected
//           grant_ls   out  LS selected
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_arb_pick (
  input  wire logic valid_if,
  input  wire logic valid_ls,
  input  wire logic favour_ls,
  output logic      grant_if,
  output logic      grant_ls
);

  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (valid_if && valid_ls) begin
      grant_ls = favour_ls;
      grant_if = !favour_ls;
    end else begin
      grant_if = valid_if;
      grant_ls = valid_ls;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rom_arbiter.sv
// ============================================================================
// Module  : rom_arbiter
// Purpose : Shares the single-port boot/instruction ROM between instruction
//           fetch (IF) and load/store (LS). One ROM access per grant, the
//           1-cycle ROM response is routed back to the owner, and illegal
//           addresses (out of range or misaligned) are answered with an
//           error response without touching the ROM.
// Ports   : clk         in   clock, all state on posedge
//           rst         in   synchronous active-high reset
//           if_port     slave channel for instruction fetch
//           ls_port     slave channel for load/store
//           rom_req     out  ROM access strobe
//           rom_addr    out  ROM byte address (0 when no access)
//           rom_rdata   in   ROM read data
//           rom_rvalid  in   ROM read data valid
// Params  : ROM_WORDS   ROM depth in 32-bit words (default from ROM_SIZE)
// Config  : ROM_ARB_RR_EN defined   -> round-robin on contention
//           ROM_ARB_RR_EN undefined -> fixed priority, LS beats IF
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int unsigned ROM_WORDS = ROM_SIZE_WORDS
) (
  input  wire logic        clk,
  input  wire logic        rst,
  rom_arbiter_if.slave     if_port,
  rom_arbiter_if.slave     ls_port,
  output logic             rom_req,
  output logic [31:0]      rom_addr,
  input  wire logic [31:0] rom_rdata,
  input  wire logic        rom_rvalid
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [0:0]    state_q, state_d;
  arb_inflight_t fl_q, fl_d;

  logic          favour_ls;
  logic          resp_back;
  logic          grant_en;
  logic          pick_if, pick_ls;
  logic          grant_if, grant_ls;
  logic          win_any;
  logic [31:0]   win_addr;
  logic          win_legal;

  // The in-flight access completes this cycle. A rejected access always
  // completes after one cycle; a ROM access completes on rom_rvalid. If the
  // ROM fails to answer we stay BUSY and refuse new grants.
  assign resp_back = (state_q == ARB_BUSY) && (fl_q.err || rom_rvalid);

  // The port can take a new request when it is free or frees up this cycle,
  // which is what gives one response per cycle on back-to-back grants.
  assign grant_en = !rst && ((state_q == ARB_IDLE) || resp_back);

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
`ifdef ROM_ARB_RR_EN
  // Preference goes to the requester that did not win the last handshake.
  logic favour_ls_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      favour_ls_q <= 1'b1;
    end else if (win_any) begin
      favour_ls_q <= grant_if;
    end
  end

  assign favour_ls = favour_ls_q;
`else
  assign favour_ls = 1'b1;
`endif

  rom_arb_pick u_pick (
    .valid_if  (if_port.req_valid),
    .valid_ls  (ls_port.req_valid),
    .favour_ls (favour_ls),
    .grant_if  (pick_if),
    .grant_ls  (pick_ls)
  );

  assign grant_if = grant_en && pick_if;
  assign grant_ls = grant_en && pick_ls;

  // A grant is only given to a valid requester, so ready == handshake.
  assign if_port.req_ready = grant_if;
  assign ls_port.req_ready = grant_ls;

  assign win_any   = grant_if || grant_ls;
  assign win_addr  = grant_ls ? ls_port.req_addr : if_port.req_addr;
  assign win_legal = addr_legal(win_addr, ROM_WORDS);

  // --------------------------------------------------------------------------
  // ROM request: issued in the grant cycle straight from the winner's
  // address. Illegal addresses never reach the ROM.
  // --------------------------------------------------------------------------
  assign rom_req  = win_any && win_legal;
  assign rom_addr = rom_req ? win_addr : 32'h0;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    fl_d    = fl_q;
    if (win_any) begin
      state_d  = ARB_BUSY;
      fl_d.owner = grant_ls ? ARB_OWN_LS : ARB_OWN_IF;
      fl_d.err   = !win_legal;
    end else if ((state_q == ARB_IDLE) || resp_back) begin
      state_d    = ARB_IDLE;
      fl_d.owner = ARB_OWN_NONE;
      fl_d.err   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      fl_q.owner <= ARB_OWN_NONE;
      fl_q.err   <= 1'b0;
    end else begin
      state_q <= state_d;
      fl_q    <= fl_d;
    end
  end

  // --------------------------------------------------------------------------
  // Response routing. Combinational from the ROM outputs so latency stays at
  // one cycle. Gated by rst so an access issued just before reset produces
  // nothing; with owner NONE a stray rom_rvalid is ignored.
  // --------------------------------------------------------------------------
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_to_if, rsp_to_ls;

  always_comb begin
    rsp_valid = 1'b0;
    rsp_data  = 32'h0;
    rsp_err   = 1'b0;
    if (fl_q.err) begin
      rsp_valid = 1'b1;
    end else begin
      rsp_valid = rom_rvalid;
      rsp_data  = rom_rdata;
    end
    rsp_err = fl_q.err;
  end

  assign rsp_to_if = !rst && (state_q == ARB_BUSY) && (fl_q.owner == ARB_OWN_IF);
  assign rsp_to_ls = !rst && (state_q == ARB_BUSY) && (fl_q.owner == ARB_OWN_LS);

  assign if_port.resp_valid = rsp_to_if && rsp_valid;
  assign if_port.resp_data  = rsp_to_if ? rsp_data : 32'h0;
  assign if_port.resp_err   = rsp_to_if && rsp_err;

  assign ls_port.resp_valid = rsp_to_ls && rsp_valid;
  assign ls_port.resp_data  = rsp_to_ls ? rsp_data : 32'h0;
  assign ls_port.resp_err   = rsp_to_ls && rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_rom_arbiter.sv
// ============================================================================
// Module  : tb_rom_arbiter
// Purpose : Self-checking bench for rom_arbiter. A small ROM model answers
//           every access one cycle later; a cycle-level reference model
//           (pending response + tie preference) predicts all arbiter outputs.
//           Honours ROM_ARB_RR_EN the same way the design does.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rom_arbiter;

  localparam int unsigned WORDS = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rom_req;
  logic [31:0] rom_addr;
  logic [31:0] rom_rdata = 32'h0;
  logic        rom_rvalid;
  logic        rvalid_q = 1'b0;
  logic        stray = 1'b0;
  logic [31:0] mem [0:WORDS-1];

  int checks = 0;
  int errors = 0;

  rom_arbiter_if if_bus ();
  rom_arbiter_if ls_bus ();

  rom_arbiter #(.ROM_WORDS(WORDS)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_port    (if_bus),
    .ls_port    (ls_bus),
    .rom_req    (rom_req),
    .rom_addr   (rom_addr),
    .rom_rdata  (rom_rdata),
    .rom_rvalid (rom_rvalid)
  );

  always #5 clk = ~clk;

  // ROM: one-cycle read latency; 'stray' injects an unsolicited valid.
  always @(posedge clk) begin
    rvalid_q  <= rom_req;
    rom_rdata <= mem[rom_addr[7:2]];
  end
  assign rom_rvalid = rvalid_q | stray;

  // Reference model state
  bit          pend_v     = 1'b0;
  bit          pend_ls    = 1'b0;
  bit          pend_legal = 1'b0;
  logic [31:0] pend_addr  = 32'h0;
  bit          fav_ls     = 1'b1;

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (a < 4 * WORDS);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, predict and check every output, advance
  // the model. Reports the model's grants and the observed strobes.
  task automatic step(input bit r, input bit iv, input logic [31:0] ia,
                      input bit lv, input logic [31:0] la,
                      output bit g_if, output bit g_ls,
                      output bit o_rdy_if, output bit o_rdy_ls,
                      output bit o_rv_if, output bit o_rv_ls);
    bit          w_if, w_ls, e_req;
    bit          e_rv_if, e_rv_ls;
    logic [31:0] w_addr, e_data;
    @(negedge clk);
    rst = r;
    if_bus.req_valid = iv; if_bus.req_addr = ia;
    ls_bus.req_valid = lv; ls_bus.req_addr = la;
    #1;
    e_rv_if = !r && pend_v && !pend_ls;
    e_rv_ls = !r && pend_v && pend_ls;
    e_data  = pend_legal ? mem[pend_addr[7:2]] : 32'h0;
    w_if = 1'b0; w_ls = 1'b0;
    if (!r) begin
      if (iv && lv) begin
`ifdef ROM_ARB_RR_EN
        w_ls = fav_ls;
`else
        w_ls = 1'b1;
`endif
        w_if = !w_ls;
      end else begin
        w_if = iv; w_ls = lv;
      end
    end
    w_addr = w_ls ? la : ia;
    e_req  = (w_if || w_ls) && legal(w_addr);
    check("if_ready", 32'(if_bus.req_ready), 32'(w_if));
    check("ls_ready", 32'(ls_bus.req_ready), 32'(w_ls));
    check("one_hot", 32'(if_bus.req_ready & ls_bus.req_ready), 32'h0);
    check("rom_req", 32'(rom_req), 32'(e_req));
    check("rom_addr", rom_addr, e_req ? w_addr : 32'h0);
    check("if_resp_valid", 32'(if_bus.resp_valid), 32'(e_rv_if));
    check("if_resp_data", if_bus.resp_data, e_rv_if ? e_data : 32'h0);
    check("if_resp_err", 32'(if_bus.resp_err), 32'(e_rv_if && !pend_legal));
    check("ls_resp_valid", 32'(ls_bus.resp_valid), 32'(e_rv_ls));
    check("ls_resp_data", ls_bus.resp_data, e_rv_ls ? e_data : 32'h0);
    check("ls_resp_err", 32'(ls_bus.resp_err), 32'(e_rv_ls && !pend_legal));
    o_rdy_if = if_bus.req_ready; o_rdy_ls = ls_bus.req_ready;
    o_rv_if  = if_bus.resp_valid; o_rv_ls = ls_bus.resp_valid;
    if (r) begin
      pend_v = 1'b0;
      fav_ls = 1'b1;
    end else begin
      pend_v     = w_if || w_ls;
      pend_ls    = w_ls;
      pend_addr  = w_addr;
      pend_legal = legal(w_addr);
      if (w_if || w_ls) fav_ls = w_if;
    end
    g_if = w_if; g_ls = w_ls;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0:       return 32'(4 * WORDS) + 32'($urandom_range(0, 15) * 4);
      1:       return 32'($urandom_range(0, WORDS - 1) * 4) | 32'($urandom_range(1, 3));
      default: return 32'($urandom_range(0, WORDS - 1) * 4);
    endcase
  endfunction

  initial begin
    bit          gi, gl, ri, rl, vi, vl;
    int          cnt_if, cnt_ls, cnt_rv;
    bit          iv, lv, r;
    logic [31:0] ia, la;

    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
    mem[4] = 32'hDEADBEEF;
    if_bus.req_valid = 1'b0; if_bus.req_addr = 32'h0;
    ls_bus.req_valid = 1'b0; ls_bus.req_addr = 32'h0;

    // Reset, with requests pending: nothing may be granted
    step(1, 1, 32'h10, 1, 32'h4, gi, gl, ri, rl, vi, vl);
    step(1, 0, 0, 0, 0, gi, gl, ri, rl, vi, vl);
    check("reset_rom_addr", rom_addr, 32'h0);

    // 1: IF only, addr 0x10
    step(0, 1, 32'h10, 0, 0, gi, gl, ri, rl, vi, vl);
    check("t1_rom_addr", rom_addr, 32'h10);
    step(0, 0, 0, 0, 0, gi, gl, ri, rl, vi, vl);
    check("t1_if_data", if_bus.resp_data, 32'hDEADBEEF);

    // 2: contention, three cycles of both valid then IF alone
    cnt_if = 0; cnt_ls = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 32'h0, 1, 32'h4, gi, gl, ri, rl, vi, vl);
      cnt_if += int'(ri); cnt_ls += int'(rl);
    end
`ifdef ROM_ARB_RR_EN
    check("t2_ls_grants", 32'(cnt_ls), 32'd2);
    check("t2_if_grants", 32'(cnt_if), 32'd1);
`else
    check("t2_ls_grants", 32'(cnt_ls), 32'd3);
    check("t2_if_grants", 32'(cnt_if), 32'd0);
`endif
    step(0, 1, 32'h0, 0, 0, gi, gl, ri, rl, vi, vl);
    step(0, 0, 0, 0, 0, gi, gl, ri, rl, vi, vl);

    // 3: LS out of range
    step(0, 0, 0, 1, 32'(4 * WORDS), gi, gl, ri, rl, vi, vl);
    check("t3_rom_req", 32'(rom_req), 32'h0);
    step(0, 0, 0, 0, 0, gi, gl, ri, rl, vi, vl);
    check("t3_ls_err", 32'(ls_bus.resp_err), 32'h1);

    // 4: LS misaligned, then a legal IF grant while the error returns
    step(0, 0, 0, 1, 32'h6, gi, gl, ri, rl, vi, vl);
    step(0, 1, 32'h8, 0, 0, gi, gl, ri, rl, vi, vl);
    check("t4_ls_err", 32'(ls_bus.resp_err), 32'h1);
    step(0, 0, 0, 0, 0, gi, gl, ri, rl, vi, vl);
    check("t4_if_data", if_bus.resp_data, mem[2]);

    // 5: reset in the cycle after a grant, then a stray rom_rvalid in IDLE
    step(0, 1, 32'hC, 0, 0, gi, gl, ri, rl, vi, vl);
    step(1, 0, 0, 0, 0, gi, gl, ri, rl, vi, vl);
    check("t5_rvalid_seen", 32'(rom_rvalid), 32'h1);
    step(0, 0, 0, 0, 0, gi, gl, ri, rl, vi, vl);
    stray = 1'b1;
    step(0, 0, 0, 0, 0, gi, gl, ri, rl, vi, vl);
    stray = 1'b0;

    // 6: continuous IF stream
    cnt_rv = 0;
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 32'(4 * i), 0, 0, gi, gl, ri, rl, vi, vl);
      if (i > 0) cnt_rv += int'(vi);
    end
    step(0, 0, 0, 0, 0, gi, gl, ri, rl, vi, vl);
    cnt_rv += int'(vi);
    check("t6_resp_count", 32'(cnt_rv), 32'd16);

    // Random traffic; requests held stable until the model grants them
    iv = 1'b0; lv = 1'b0; ia = 32'h0; la = 32'h0;
    for (int n = 0; n < 400; n++) begin
      if (!iv && $urandom_range(0, 2) != 0) begin iv = 1'b1; ia = rand_addr(); end
      if (!lv && $urandom_range(0, 2) != 0) begin lv = 1'b1; la = rand_addr(); end
      r = ($urandom_range(0, 59) == 0);
      step(r, iv, ia, lv, la, gi, gl, ri, rl, vi, vl);
      if (gi) iv = 1'b0;
      if (gl) lv = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
